// File: rtl/temp_pkg.sv
// Shared types and helpers for the temperature sample scheduler: one-hot state
// encoding, fixed-point scale, and sign/magnitude <-> signed conversions.
package temp_pkg;

    localparam int TEMP_W = 24;
    localparam int SCALE  = 10000;      // 0.0001 C per LSB
    localparam int SVAL_W = TEMP_W + 2;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_TRIG  = 6'b000010,
        S_WAIT  = 6'b000100,
        S_ACCUM = 6'b001000,
        S_HOLD  = 6'b010000,
        S_FAULT = 6'b100000
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [TEMP_W-1:0] mag;
    } sm_t;

    function automatic logic signed [SVAL_W-1:0] sm_to_signed(input logic sign,
                                                              input logic [TEMP_W-1:0] mag);
        logic signed [SVAL_W-1:0] m;
        m = $signed({2'b00, mag});
        return sign ? -m : m;
    endfunction

    // Magnitude saturates when the absolute value no longer fits TEMP_W bits.
    function automatic sm_t signed_to_sm(input logic signed [SVAL_W-1:0] v);
        logic [SVAL_W-1:0] a;
        sm_t               r;
        a      = v[SVAL_W-1] ? -v : v;
        r.sign = v[SVAL_W-1];
        r.mag  = (a[SVAL_W-1:TEMP_W] != '0) ? '1 : a[TEMP_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: 1 us prescaler feeding a 0..999 us counter and an ms
// counter; clr restarts it, tc is high while the ms count equals limit.
module ms_timer #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int MS_W         = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            run,
    input  logic [MS_W-1:0] limit,
    output logic            tc
);

    localparam int PRE_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    logic [PRE_W-1:0] pre;
    logic [9:0]       us;
    logic [MS_W-1:0]  ms;
    logic             us_tick;
    logic             ms_tick;

    assign us_tick = (pre == PRE_W'(CLK_FREQ_MHZ - 1));
    assign ms_tick = us_tick && (us == 10'd999);
    assign tc      = (ms == limit);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre <= '0;
            us  <= '0;
            ms  <= '0;
        end else if (run && !tc) begin
            pre <= us_tick ? '0 : pre + PRE_W'(1);
            if (us_tick) us <= (us == 10'd999) ? '0 : us + 10'd1;
            if (ms_tick) ms <= ms + MS_W'(1);
        end
    end

endmodule

// File: rtl/temp_sample_scheduler.sv
// Sequences a triggered DS18B20 driver: periodic start, timeout/retry, averaging
// and hysteretic alarm. Define SPIKE_REJECT_EN to enable step-based spike rejection.
module temp_sample_scheduler
    import temp_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int PERIOD_MS    = 1000,
    parameter int TIMEOUT_MS   = 1000,
    parameter int MAX_RETRY    = 3,
    parameter int AVG_LOG2     = 2,
    parameter int HI_TH        = 30 * SCALE,
    parameter int HYST         = SCALE
`ifdef SPIKE_REJECT_EN
    , parameter int MAX_STEP   = 50000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        start_req,
    input  logic        temp_sign,
    input  logic [23:0] temp_out,
    input  logic        temp_out_vld,
    output logic        avg_sign,
    output logic [23:0] avg_temp,
    output logic        avg_vld,
    output logic        alarm,
    output logic        sensor_fault,
    output logic [1:0]  retry_cnt
);

    localparam int ACC_W  = SVAL_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int MS_MAX = (PERIOD_MS > TIMEOUT_MS) ? PERIOD_MS : TIMEOUT_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    localparam logic signed [SVAL_W-1:0] SET_TH    = SVAL_W'(HI_TH);
    localparam logic signed [SVAL_W-1:0] CLR_TH    = SVAL_W'(HI_TH - HYST);
    localparam logic [1:0]               RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(2**AVG_LOG2 - 1);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_sum;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [SVAL_W-1:0] sample_q, sample_in, mean;
    logic [1:0]               retry_q, retry_inc;
    logic                     tc, clr, run, accept;
    logic [MS_W-1:0]          limit;

    assign sample_in = sm_to_signed(temp_sign, temp_out);
    assign retry_inc = retry_q + 2'd1;
    assign acc_sum   = acc_q + ACC_W'(sample_q);
    assign mean      = SVAL_W'(acc_sum >>> AVG_LOG2);   // floor toward -inf

`ifdef SPIKE_REJECT_EN
    localparam logic signed [SVAL_W:0] STEP_MAX = (SVAL_W+1)'(MAX_STEP);

    logic signed [SVAL_W-1:0] last_q;
    logic                     have_last_q;
    logic [1:0]               rej_q;
    logic signed [SVAL_W:0]   step;

    assign step   = (SVAL_W+1)'(sample_in) - (SVAL_W+1)'(last_q);
    assign accept = !have_last_q || (rej_q == 2'd2) ||
                    ((step <= STEP_MAX) && (step >= -STEP_MAX));
`else
    assign accept = 1'b1;
`endif

    // Timer restarts on every state entry; the limit follows the active state.
    assign run   = (state_q == S_TRIG) || (state_q == S_WAIT) || (state_q == S_HOLD);
    assign clr   = (state_d != state_q);
    assign limit = (state_q == S_WAIT) ? MS_W'(TIMEOUT_MS) : MS_W'(PERIOD_MS);

    ms_timer #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ),
        .MS_W        (MS_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .run  (run),
        .limit(limit),
        .tc   (tc)
    );

    assign start_req    = (state_q == S_TRIG);
    assign sensor_fault = (state_q == S_FAULT);
    assign retry_cnt    = retry_q;

    // NOTE: next state gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_TRIG;
                S_TRIG:  state_d = S_WAIT;
                S_WAIT: begin
                    if (temp_out_vld)
                        state_d = accept ? S_ACCUM : S_HOLD;
                    else if (tc)
                        state_d = (retry_inc == RETRY_MAX) ? S_FAULT : S_TRIG;
                end
                S_ACCUM: state_d = S_HOLD;
                S_HOLD:  if (tc) state_d = S_TRIG;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sample_q    <= '0;
            retry_q     <= '0;
            avg_sign    <= 1'b0;
            avg_temp    <= '0;
            avg_vld     <= 1'b0;
            alarm       <= 1'b0;
`ifdef SPIKE_REJECT_EN
            last_q      <= '0;
            have_last_q <= 1'b0;
            rej_q       <= '0;
`endif
        end else begin
            avg_vld <= 1'b0;
            if (!en) begin
                acc_q       <= '0;
                cnt_q       <= '0;
                retry_q     <= '0;
`ifdef SPIKE_REJECT_EN
                have_last_q <= 1'b0;
                rej_q       <= '0;
`endif
            end else begin
                case (state_q)
                    S_WAIT: begin
                        if (temp_out_vld) begin
                            if (accept) begin
                                sample_q    <= sample_in;
                                retry_q     <= '0;
`ifdef SPIKE_REJECT_EN
                                last_q      <= sample_in;
                                have_last_q <= 1'b1;
                                rej_q       <= '0;
`endif
                            end
`ifdef SPIKE_REJECT_EN
                            else rej_q <= rej_q + 2'd1;
`endif
                        end else if (tc) begin
                            retry_q <= retry_inc;
                        end
                    end
                    S_ACCUM: begin
                        if (cnt_q == CNT_LAST) begin
                            acc_q                <= '0;
                            cnt_q                <= '0;
                            avg_vld              <= 1'b1;
                            {avg_sign, avg_temp} <= signed_to_sm(mean);
                            if (mean >= SET_TH)     alarm <= 1'b1;
                            else if (mean < CLR_TH) alarm <= 1'b0;
                        end else begin
                            acc_q <= acc_sum;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
